// File: rtl/ifp_pkg.sv
// ifp_pkg
// Shared types and constants for the instruction prefetch buffer.
//   ifp_state_t : fetch FSM states (IDLE, WAIT, DISCARD)
//   ifp_entry_t : one buffered fetch result, PC plus instruction word
//   IFP_PC_STEP : word-addressed sequential fetch increment
package ifp_pkg;

    localparam int IFP_AW      = 16;
    localparam int IFP_DW      = 16;
    localparam int IFP_PC_STEP = 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        DISCARD = 2'd2
    } ifp_state_t;

    typedef struct packed {
        logic [IFP_AW-1:0] pc;
        logic [IFP_DW-1:0] instr;
    } ifp_entry_t;

endpackage

// File: rtl/ifp_fifo.sv
// ifp_fifo
// Small circular FIFO holding fetched {pc, instr} entries.
// Ports:
//   clk, rst     : clock and asynchronous active-low reset
//   push, pop    : enqueue push_data / drop the head entry
//   flush        : empty the FIFO; takes priority over push and pop
//   push_data    : entry written on push
//   head         : oldest entry (storage contents, valid when !empty)
//   count        : number of stored entries
//   empty, full  : occupancy flags
module ifp_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 32,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          push,
    input  logic          pop,
    input  logic          flush,
    input  logic [W-1:0]  push_data,
    output logic [W-1:0]  head,
    output logic [CW-1:0] count,
    output logic          empty,
    output logic          full
);

    localparam int PW = $clog2(DEPTH);

    logic [W-1:0]  storage [DEPTH];
    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count == '0);
    assign full    = (count == CW'(DEPTH));
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = storage[rd_ptr];

    // Pointers wrap naturally because DEPTH is a power of two; a flush
    // simply rewinds both pointers and forgets every entry.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + PW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Entry storage needs no reset: the head is only meaningful while the
    // FIFO is non-empty, and the top masks it otherwise.
    always_ff @(posedge clk) begin
        if (do_push && !flush) storage[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/ifetch_prefetch.sv
// ifetch_prefetch
// Instruction prefetch buffer between the instruction memory port and
// IF_slice. Issues one sequential read at a time, buffers returned words
// with their PC, and flushes on any branch/call/return redirect.
// Ports:
//   clk, rst            : clock and asynchronous active-low reset
//   hlt                 : block new memory requests
//   redirect/redirect_pc: flush and restart fetch at redirect_pc
//   stall               : IF_slice not consuming the head this cycle
//   mem_req/mem_addr    : one-cycle read strobe and its address
//   mem_rvalid/mem_rdata: read response (one cycle or more after request)
//   instr_valid         : buffer holds at least one entry
//   instr/pc/pc_inc     : head instruction, its PC, and PC+1
module ifetch_prefetch
    import ifp_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter int          AW       = 16,
    parameter int          DW       = 16,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          hlt,
    input  logic          redirect,
    input  logic [AW-1:0] redirect_pc,
    input  logic          stall,
    output logic          mem_req,
    output logic [AW-1:0] mem_addr,
    input  logic          mem_rvalid,
    input  logic [DW-1:0] mem_rdata,
    output logic          instr_valid,
    output logic [DW-1:0] instr,
    output logic [AW-1:0] pc,
    output logic [AW-1:0] pc_inc
);

    localparam int CW = $clog2(DEPTH) + 1;

    ifp_state_t       state;
    logic [AW-1:0]    fetch_pc;
    logic [CW-1:0]    count;
    logic             empty;
    logic             full;
    logic [AW+DW-1:0] head;
    logic             outstanding;
    logic             can_issue;
    logic             push;
    logic             deq;

    // A request is only allowed when the buffer has room for its response
    // even counting the one still in flight, so the FIFO can never overflow.
    assign outstanding = (state == WAIT);
    assign can_issue   = !hlt && ((count + CW'(outstanding)) < CW'(DEPTH));

    // Requests only leave from IDLE; a redirect defers the request by a
    // cycle so it goes out with the new address. Reset forces it low.
    assign mem_req  = rst && (state == IDLE) && can_issue && !redirect;
    assign mem_addr = fetch_pc;

    // Responses are kept only when they belong to the current fetch stream,
    // and redirect overrides both push and dequeue.
    assign push        = (state == WAIT) && mem_rvalid && !redirect;
    assign instr_valid = !empty;
    assign deq         = instr_valid && !stall && !redirect;

    // Head outputs read as zero while empty so stale entries never leak.
    assign pc     = empty ? '0 : head[AW+DW-1:DW];
    assign instr  = empty ? '0 : head[DW-1:0];
    assign pc_inc = pc + AW'(IFP_PC_STEP);

    ifp_fifo #(
        .DEPTH (DEPTH),
        .W     (AW + DW),
        .CW    (CW)
    ) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .push      (push),
        .pop       (deq),
        .flush     (redirect),
        .push_data ({fetch_pc, mem_rdata}),
        .head      (head),
        .count     (count),
        .empty     (empty),
        .full      (full)
    );

    // Fetch FSM. DISCARD swallows the response of a request that was
    // overtaken by a redirect; the new stream starts once it has arrived,
    // keeping at most one read in flight. A response landing in DISCARD
    // together with another redirect still retires the old request.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            fetch_pc <= RESET_PC;
        end else begin
            case (state)
                IDLE: begin
                    if (redirect)     fetch_pc <= redirect_pc;
                    else if (mem_req) state    <= WAIT;
                end
                WAIT: begin
                    if (redirect) begin
                        fetch_pc <= redirect_pc;
                        state    <= mem_rvalid ? IDLE : DISCARD;
                    end else if (mem_rvalid) begin
                        fetch_pc <= fetch_pc + AW'(IFP_PC_STEP);
                        state    <= IDLE;
                    end
                end
                DISCARD: begin
                    if (redirect)   fetch_pc <= redirect_pc;
                    if (mem_rvalid) state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // A response with nothing outstanding means the memory side is broken.
    a_no_rvalid_in_idle: assert property (@(posedge clk) disable iff (!rst)
        !(state == IDLE && mem_rvalid));

    // Credit accounting must keep pushes away from a full buffer.
    a_no_push_when_full: assert property (@(posedge clk) disable iff (!rst)
        !(push && full && !deq));

endmodule

// File: tb/tb_ifetch_prefetch.sv
// tb_ifetch_prefetch
// Self-checking bench for ifetch_prefetch. A memory responder answers each
// request with 16'hA000+addr after a chosen latency; each test task drives
// its scenario and compares against expectations derived from fetch-stream
// rules (sequential PCs, restart at redirect targets, one read in flight).
module tb_ifetch_prefetch;

    logic        clk = 1'b0;
    logic        rst;
    logic        hlt;
    logic        redirect;
    logic [15:0] redirect_pc;
    logic        stall;
    logic        mem_req;
    logic [15:0] mem_addr;
    logic        mem_rvalid;
    logic [15:0] mem_rdata;
    logic        instr_valid;
    logic [15:0] instr;
    logic [15:0] pc;
    logic [15:0] pc_inc;

    int n_checks = 0;
    int n_fail   = 0;

    int          mem_lat  = 1;
    bit          rand_lat = 1'b0;
    bit          pend     = 1'b0;
    bit          mem_busy = 1'b0;
    int          pend_cnt = 0;
    logic [15:0] pend_addr = '0;

    ifetch_prefetch #(
        .DEPTH    (4),
        .AW       (16),
        .DW       (16),
        .RESET_PC (16'h0000)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .hlt         (hlt),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .stall       (stall),
        .mem_req     (mem_req),
        .mem_addr    (mem_addr),
        .mem_rvalid  (mem_rvalid),
        .mem_rdata   (mem_rdata),
        .instr_valid (instr_valid),
        .instr       (instr),
        .pc          (pc),
        .pc_inc      (pc_inc)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] mem_word(input logic [15:0] a);
        return 16'hA000 + a;
    endfunction

    // Memory responder: every input change happens at the falling edge, the
    // request seen just after it is the one the DUT samples at the next rise.
    initial begin
        mem_rvalid = 1'b0;
        mem_rdata  = '0;
        forever begin
            @(negedge clk);
            mem_rvalid = 1'b0;
            if (pend) begin
                pend_cnt--;
                if (pend_cnt == 0) begin
                    mem_rvalid = 1'b1;
                    mem_rdata  = mem_word(pend_addr);
                    pend       = 1'b0;
                end
            end
            mem_busy = pend;
            #1;
            if (!rst) begin
                pend       = 1'b0;
                mem_busy   = 1'b0;
                mem_rvalid = 1'b0;
            end else if (mem_req) begin
                pend      = 1'b1;
                pend_cnt  = rand_lat ? int'($urandom_range(1, 3)) : mem_lat;
                pend_addr = mem_addr;
            end
        end
    end

    // Holds reset for two edges and releases it just after a rising edge,
    // so the next falling edge starts the first post-reset cycle.
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b0; hlt = 1'b0; redirect = 1'b0; stall = 1'b0;
        redirect_pc = '0; rand_lat = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0; hlt = 1'b0; redirect = 1'b0; stall = 1'b0;
        redirect_pc = '0; mem_lat = 1; rand_lat = 1'b0;
        #2;
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_instr_valid got=%0b want=0", instr_valid); end
        n_checks++; if (instr !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_instr got=%h want=0000", instr); end
        n_checks++; if (pc !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_pc got=%h want=0000", pc); end
        n_checks++; if (pc_inc !== 16'h0001) begin n_fail++; $display("[TB] FAIL reset_pc_inc got=%h want=0001", pc_inc); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL reset_mem_req got=%0b want=0", mem_req); end
        @(posedge clk);
        #2 rst = 1'b1;
        @(negedge clk); #2;
        n_checks++; if (mem_req !== 1'b1) begin n_fail++; $display("[TB] FAIL reset_first_req got=%0b want=1", mem_req); end
        n_checks++; if (mem_addr !== 16'h0000) begin n_fail++; $display("[TB] FAIL reset_first_addr got=%h want=0000", mem_addr); end
    endtask

    task automatic test_sequential();
        logic [15:0] req_q[$];
        logic [15:0] exp_pc;
        int first_req, first_valid, ncons;
        do_reset();
        mem_lat = 1;
        exp_pc = 16'h0000; first_req = -1; first_valid = -1; ncons = 0;
        for (int cyc = 0; cyc < 20; cyc++) begin
            @(negedge clk); #2;
            if (mem_req) begin
                if (first_req < 0) first_req = cyc;
                req_q.push_back(mem_addr);
            end
            if (instr_valid) begin
                if (first_valid < 0) first_valid = cyc;
                n_checks++; if (pc !== exp_pc) begin n_fail++; $display("[TB] FAIL seq_pc got=%h want=%h", pc, exp_pc); end
                n_checks++; if (instr !== mem_word(exp_pc)) begin n_fail++; $display("[TB] FAIL seq_instr got=%h want=%h", instr, mem_word(exp_pc)); end
                n_checks++; if (pc_inc !== exp_pc + 16'd1) begin n_fail++; $display("[TB] FAIL seq_pc_inc got=%h want=%h", pc_inc, exp_pc + 16'd1); end
                exp_pc++;
                ncons++;
            end
        end
        for (int i = 0; i < 4; i++) begin
            n_checks++;
            if (req_q.size() <= i || req_q[i] !== 16'(i)) begin
                n_fail++;
                $display("[TB] FAIL seq_req_addr idx=%0d got=%h want=%h", i, (req_q.size() > i) ? req_q[i] : 16'hxxxx, 16'(i));
            end
        end
        n_checks++; if (first_req < 0 || first_valid != first_req + 2) begin n_fail++; $display("[TB] FAIL seq_first_valid got=%0d want=%0d", first_valid, first_req + 2); end
        n_checks++; if (ncons != 9) begin n_fail++; $display("[TB] FAIL seq_throughput got=%0d want=9", ncons); end
    endtask

    task automatic test_stall_fill();
        logic [15:0] exp_pc;
        int nreq, ncons;
        logic [15:0] resume_addr;
        bit resumed;
        do_reset();
        mem_lat = 1;
        stall = 1'b1;
        nreq = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            @(negedge clk); #2;
            if (mem_req) nreq++;
        end
        n_checks++; if (nreq != 4) begin n_fail++; $display("[TB] FAIL fill_req_count got=%0d want=4", nreq); end
        n_checks++; if (instr_valid !== 1'b1 || pc !== 16'h0000) begin n_fail++; $display("[TB] FAIL fill_head got=%0b/%h want=1/0000", instr_valid, pc); end
        exp_pc = 16'h0000; ncons = 0; resumed = 1'b0; resume_addr = '0;
        for (int cyc = 0; cyc < 16; cyc++) begin
            @(negedge clk);
            stall = 1'b0;
            #2;
            if (mem_req && !resumed) begin resumed = 1'b1; resume_addr = mem_addr; end
            if (instr_valid) begin
                n_checks++; if (pc !== exp_pc || instr !== mem_word(exp_pc)) begin n_fail++; $display("[TB] FAIL drain_entry got=%h/%h want=%h/%h", pc, instr, exp_pc, mem_word(exp_pc)); end
                exp_pc++;
                ncons++;
            end
        end
        n_checks++; if (!resumed || resume_addr !== 16'h0004) begin n_fail++; $display("[TB] FAIL resume_addr got=%h want=0004", resume_addr); end
        n_checks++; if (ncons < 5) begin n_fail++; $display("[TB] FAIL drain_count got=%0d want>=5", ncons); end
    endtask

    task automatic test_redirect_wait();
        int resp_cyc, req_cyc;
        logic [15:0] req_addr;
        bit got_valid;
        do_reset();
        mem_lat = 3;
        resp_cyc = -1; req_cyc = -1; req_addr = '0; got_valid = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk);
            redirect    = (cyc == 1);
            redirect_pc = 16'h0040;
            #2;
            if (mem_rvalid && resp_cyc < 0) resp_cyc = cyc;
            if (cyc > 1 && mem_req && req_cyc < 0) begin req_cyc = cyc; req_addr = mem_addr; end
            if (instr_valid && !got_valid) begin
                got_valid = 1'b1;
                n_checks++; if (pc !== 16'h0040 || instr !== 16'hA040) begin n_fail++; $display("[TB] FAIL redir_first_entry got=%h/%h want=0040/a040", pc, instr); end
            end
        end
        redirect = 1'b0;
        n_checks++; if (req_addr !== 16'h0040) begin n_fail++; $display("[TB] FAIL redir_next_addr got=%h want=0040", req_addr); end
        n_checks++; if (resp_cyc < 0 || req_cyc != resp_cyc + 1) begin n_fail++; $display("[TB] FAIL redir_req_timing got=%0d want=%0d", req_cyc, resp_cyc + 1); end
        n_checks++; if (!got_valid) begin n_fail++; $display("[TB] FAIL redir_no_valid got=0 want=1"); end
    endtask

    task automatic test_redirect_same_cycle();
        bit found;
        logic [15:0] exp_pc;
        int ncons;
        do_reset();
        mem_lat = 1;
        stall = 1'b1;
        found = 1'b0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            @(negedge clk); #2;
            if (mem_rvalid && instr_valid) begin
                found = 1'b1;
                stall = 1'b0; redirect = 1'b1; redirect_pc = 16'h0123;
                break;
            end
        end
        n_checks++; if (!found) begin n_fail++; $display("[TB] FAIL same_setup got=0 want=1"); end
        @(negedge clk);
        redirect = 1'b0;
        #2;
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL same_flush got=%0b want=0", instr_valid); end
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0123) begin n_fail++; $display("[TB] FAIL same_next_req got=%0b/%h want=1/0123", mem_req, mem_addr); end
        exp_pc = 16'h0123; ncons = 0;
        for (int cyc = 0; cyc < 10; cyc++) begin
            @(negedge clk); #2;
            if (instr_valid) begin
                n_checks++; if (pc !== exp_pc || instr !== mem_word(exp_pc)) begin n_fail++; $display("[TB] FAIL same_entry got=%h/%h want=%h/%h", pc, instr, exp_pc, mem_word(exp_pc)); end
                exp_pc++;
                ncons++;
            end
        end
        n_checks++; if (ncons < 1) begin n_fail++; $display("[TB] FAIL same_resume got=%0d want>=1", ncons); end
    endtask

    task automatic test_wrap();
        logic [15:0] req_q[$];
        bit seen;
        do_reset();
        mem_lat = 1;
        @(negedge clk);
        redirect = 1'b1; redirect_pc = 16'hFFFF;
        #2;
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL wrap_req_on_redirect got=%0b want=0", mem_req); end
        seen = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            redirect = 1'b0;
            #2;
            if (mem_req) req_q.push_back(mem_addr);
            if (instr_valid && !seen) begin
                seen = 1'b1;
                n_checks++; if (pc !== 16'hFFFF) begin n_fail++; $display("[TB] FAIL wrap_pc got=%h want=ffff", pc); end
                n_checks++; if (pc_inc !== 16'h0000) begin n_fail++; $display("[TB] FAIL wrap_pc_inc got=%h want=0000", pc_inc); end
                n_checks++; if (instr !== 16'h9FFF) begin n_fail++; $display("[TB] FAIL wrap_instr got=%h want=9fff", instr); end
            end
        end
        n_checks++; if (req_q.size() < 2 || req_q[0] !== 16'hFFFF || req_q[1] !== 16'h0000) begin n_fail++; $display("[TB] FAIL wrap_addrs got_n=%0d want=ffff,0000", req_q.size()); end
        n_checks++; if (!seen) begin n_fail++; $display("[TB] FAIL wrap_no_entry got=0 want=1"); end
    endtask

    task automatic test_hlt();
        int nreq, ncons;
        do_reset();
        mem_lat = 2;
        @(negedge clk); #2;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin n_fail++; $display("[TB] FAIL hlt_first_req got=%0b/%h want=1/0000", mem_req, mem_addr); end
        nreq = 0; ncons = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk);
            hlt = 1'b1;
            #2;
            if (mem_req) nreq++;
            if (instr_valid) begin
                n_checks++; if (pc !== 16'h0000 || instr !== 16'hA000) begin n_fail++; $display("[TB] FAIL hlt_entry got=%h/%h want=0000/a000", pc, instr); end
                ncons++;
            end
        end
        n_checks++; if (nreq != 0) begin n_fail++; $display("[TB] FAIL hlt_req_count got=%0d want=0", nreq); end
        n_checks++; if (ncons != 1) begin n_fail++; $display("[TB] FAIL hlt_pushed got=%0d want=1", ncons); end
        @(negedge clk);
        hlt = 1'b0;
        #2;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0001) begin n_fail++; $display("[TB] FAIL hlt_release got=%0b/%h want=1/0001", mem_req, mem_addr); end
    endtask

    task automatic test_reset_mid();
        bit found;
        bit seen;
        do_reset();
        mem_lat = 3;
        stall = 1'b1;
        found = 1'b0;
        for (int cyc = 0; cyc < 40; cyc++) begin
            @(negedge clk); #2;
            if (mem_req && instr_valid) begin found = 1'b1; break; end
        end
        n_checks++; if (!found) begin n_fail++; $display("[TB] FAIL rstmid_setup got=0 want=1"); end
        @(negedge clk);
        rst = 1'b0;
        #2;
        n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_valid got=%0b want=0", instr_valid); end
        n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL rstmid_req got=%0b want=0", mem_req); end
        n_checks++; if (pc !== 16'h0000 || instr !== 16'h0000) begin n_fail++; $display("[TB] FAIL rstmid_head got=%h/%h want=0000/0000", pc, instr); end
        @(posedge clk);
        #2 rst = 1'b1; stall = 1'b0;
        @(negedge clk); #2;
        n_checks++; if (mem_req !== 1'b1 || mem_addr !== 16'h0000) begin n_fail++; $display("[TB] FAIL rstmid_first_req got=%0b/%h want=1/0000", mem_req, mem_addr); end
        seen = 1'b0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            @(negedge clk); #2;
            if (instr_valid && !seen) begin
                seen = 1'b1;
                n_checks++; if (pc !== 16'h0000 || instr !== 16'hA000) begin n_fail++; $display("[TB] FAIL rstmid_entry got=%h/%h want=0000/a000", pc, instr); end
            end
        end
        n_checks++; if (!seen) begin n_fail++; $display("[TB] FAIL rstmid_no_entry got=0 want=1"); end
    endtask

    task automatic test_random();
        logic [15:0] exp_pc, next_req;
        bit after_redirect;
        int ncons;
        do_reset();
        rand_lat = 1'b1;
        exp_pc = 16'h0000; next_req = 16'h0000; after_redirect = 1'b0; ncons = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            @(negedge clk);
            stall       = ($urandom_range(0, 3) == 0);
            hlt         = ($urandom_range(0, 7) == 0);
            redirect    = ($urandom_range(0, 19) == 0);
            redirect_pc = 16'($urandom);
            #2;
            if (after_redirect) begin
                n_checks++; if (instr_valid !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd_flush cyc=%0d got=%0b want=0", cyc, instr_valid); end
            end
            if (hlt || redirect || mem_busy || mem_rvalid) begin
                n_checks++; if (mem_req !== 1'b0) begin n_fail++; $display("[TB] FAIL rnd_req_blocked cyc=%0d got=%0b want=0", cyc, mem_req); end
            end
            if (mem_req) begin
                n_checks++; if (mem_addr !== next_req) begin n_fail++; $display("[TB] FAIL rnd_req_addr cyc=%0d got=%h want=%h", cyc, mem_addr, next_req); end
                next_req = mem_addr + 16'd1;
            end
            if (instr_valid && !stall && !redirect) begin
                n_checks++;
                if (pc !== exp_pc || instr !== mem_word(exp_pc) || pc_inc !== exp_pc + 16'd1) begin
                    n_fail++;
                    $display("[TB] FAIL rnd_entry cyc=%0d got=%h/%h/%h want=%h/%h/%h", cyc, pc, instr, pc_inc, exp_pc, mem_word(exp_pc), exp_pc + 16'd1);
                end
                exp_pc++;
                ncons++;
            end
            if (redirect) begin
                exp_pc   = redirect_pc;
                next_req = redirect_pc;
            end
            after_redirect = redirect;
        end
        @(negedge clk);
        stall = 1'b0; hlt = 1'b0; redirect = 1'b0;
        n_checks++; if (ncons < 50) begin n_fail++; $display("[TB] FAIL rnd_progress got=%0d want>=50", ncons); end
    endtask

    initial begin
        rst = 1'b0; hlt = 1'b0; redirect = 1'b0; stall = 1'b0; redirect_pc = '0;
        test_reset();
        test_sequential();
        test_stall_fill();
        test_redirect_wait();
        test_redirect_same_cycle();
        test_wrap();
        test_hlt();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    // Guards against a run that stops advancing through its scenarios.
    initial begin
        #500000;
        $display("[TB] FAIL timeout got=running want=finished");
        $fatal(1, "[TB] timeout");
    end

endmodule

// File: doc/ifetch_prefetch.md
Name: ifetch_prefetch

Overview:
Instruction prefetch buffer between the instruction memory port and IF_slice.
- Generates sequential fetch addresses and issues one memory read at a time.
- Stores returned instruction words with their PC in a small FIFO and presents the head to IF_slice.
- On a branch, call or return redirect it flushes the FIFO and discards any in-flight response. This lets IF_slice tolerate multi-cycle instruction memory.

Parameters:
- DEPTH, 4, FIFO entries (power of two, ≥2).
- RESET_PC, 16'h0000, fetch address after reset.
- AW, 16, address/PC width.
- DW, 16, instruction width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-low reset.
- hlt  in  1  halt: no new memory requests while high.
- redirect  in  1  taken branch, call or return (OR of Branch/Call/Ret).
- redirect_pc  in  AW  new fetch address, valid with redirect.
- stall  in  1  IF_slice stall; head not consumed while high.
- mem_req  out  1  one-cycle read request strobe.
- mem_addr  out  AW  read address, valid with mem_req.
- mem_rvalid  in  1  read data valid; latency ≥1 cycle after mem_req.
- mem_rdata  in  DW  read data.
- instr_valid  out  1  FIFO non-empty.
- instr  out  DW  head instruction.
- pc  out  AW  head PC.
- pc_inc  out  AW  pc+1, modulo 2^AW.

Behaviour:
- Word addressing: the sequential next PC is fetch_pc+1; 16'hFFFF wraps to 16'h0000.
- Reset (rst low, asynchronous):
  - state=IDLE, fetch_pc=RESET_PC, FIFO empty.
  - instr_valid=0, instr=0, pc=0, pc_inc=1, mem_req=0.
- Dequeue: deq = instr_valid && !stall && !redirect. Head outputs are combinational from FIFO storage.
- Credit rule: can_issue = !hlt && (count + outstanding) < DEPTH, where outstanding = (state==WAIT). The FIFO can therefore never overflow.
- FSM (IDLE, WAIT, DISCARD):
  - IDLE:
    - mem_req = can_issue && !redirect; mem_addr = fetch_pc.
    - If mem_req → WAIT.
    - If redirect: fetch_pc ← redirect_pc, FIFO flushed, stay IDLE; the request is issued the next cycle.
  - WAIT:
    - mem_rvalid && !redirect: push {fetch_pc, mem_rdata}, fetch_pc ← fetch_pc+1, → IDLE.
    - redirect without mem_rvalid: flush, fetch_pc ← redirect_pc, → DISCARD.
    - redirect with mem_rvalid in the same cycle: the response is dropped, flush, fetch_pc ← redirect_pc, → IDLE.
  - DISCARD:
    - mem_rvalid: no push, → IDLE.
    - redirect: fetch_pc ← redirect_pc, flush, stay DISCARD.
- Latency: a response pushed at edge N gives instr_valid=1 from cycle N+1. With 1-cycle memory latency, steady-state throughput is one instruction per 2 cycles.
- Push and dequeue in the same cycle are both performed; count is unchanged.
- Redirect has priority over deq and push. FIFO pointers and count are cleared at the edge, so instr_valid=0 the cycle after redirect.
- hlt only blocks new requests:
  - An outstanding request still completes and is pushed.
  - Dequeue continues normally.
- mem_rvalid while in IDLE is illegal. It is ignored, and an assertion fires in simulation.
- Reset mid-operation returns the block to the reset values immediately. A late mem_rvalid after reset release, arriving in IDLE, is ignored.

Decomposition:
- Package ifp_pkg:
  - typedef enum ifp_state_t {IDLE, WAIT, DISCARD}.
  - typedef struct ifp_entry_t {pc[AW], instr[DW]}.
  - localparam IFP_PC_STEP = 1.
- One sub-module, ifp_fifo:
  - Parameterised by DEPTH; push/pop/flush inputs.
  - Head entry, count and empty/full outputs.
  - Async active-low reset.
- FSM and PC logic stay in ifetch_prefetch.

Test Plan:
- Reset release, RESET_PC=0, 1-cycle memory returning 16'hA000+addr, stall=0 → mem_addr sequence 0,1,2,3. IF side sees (pc,instr) = (0,A000),(1,A001),(2,A002),… with instr_valid first high 2 cycles after the first mem_req.
- stall held high, memory latency 1 → exactly DEPTH=4 entries accepted and mem_req stays 0. Releasing stall drains PCs 0..3 in order, and fetch resumes at addr 4.
- Redirect to 16'h0040 while in WAIT with a 3-cycle memory → the late response is not pushed. The next mem_addr is 16'h0040 and the first instr_valid has pc=16'h0040.
- Redirect in the same cycle as mem_rvalid and a deq → no push, FIFO empty next cycle, next mem_addr = redirect_pc.
- fetch_pc at 16'hFFFF → pushed entry has pc=16'hFFFF and pc_inc=16'h0000; the next mem_addr is 16'h0000.
- hlt asserted in WAIT → the pending response is pushed and no further mem_req occurs. rst pulsed low mid-WAIT → instr_valid=0 and mem_req=0 immediately, and the first request after release uses RESET_PC.
